// File: rtl/apb_timer_slave.sv
// APB3 completer wrapping a 32-bit prescaled timer with compare match,
// optional auto-reload and a registered level interrupt.
//
// state  | meaning
// IDLE   | no transfer in progress
// SETUP  | setup phase seen at the last edge; current cycle is the first access cycle
// ACCESS | later access cycles, counting down the remaining wait states
module apb_timer_slave #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          WAIT_STATES    = 0,
  parameter logic [15:0] PRESCALE_RESET = 16'h0000
) (
  input  logic                  io_mainClk,
  input  logic                  io_asyncReset,
  input  logic [ADDR_WIDTH-1:0] s_apb_paddr,
  input  logic                  s_apb_psel,
  input  logic                  s_apb_penable,
  input  logic                  s_apb_pwrite,
  input  logic [31:0]           s_apb_pwdata,
  output logic                  s_apb_pready,
  output logic [31:0]           s_apb_prdata,
  output logic                  s_apb_pslverror,
  output logic                  irq
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        xfer_done;

  logic        ctrl_en, ctrl_ar, ctrl_ie;
  logic [15:0] prescale;
  logic [15:0] presc_cnt;
  logic [31:0] compare;
  logic [31:0] count;
  logic        pending;

  logic [2:0]  addr_idx;
  logic        addr_err;
  logic        wr_en;
  logic        tick, match;
  logic [31:0] rdata;
  logic        unused_addr_bits;

  assign addr_idx         = s_apb_paddr[4:2];
  assign addr_err         = (addr_idx > 3'd4);
  assign unused_addr_bits = ^{s_apb_paddr[ADDR_WIDTH-1:5], s_apb_paddr[1:0]};

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Leaving the access phase without a completion is an abort: no pready, no write.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    xfer_done    = 1'b0;
    case (state)
      IDLE: begin
        if (s_apb_psel && !s_apb_penable) begin
          state_nxt    = SETUP;
          wait_cnt_nxt = WAIT_LOAD;
        end
      end
      SETUP, ACCESS: begin
        if (!(s_apb_psel && s_apb_penable)) begin
          if (s_apb_psel && !s_apb_penable) begin
            state_nxt    = SETUP;
            wait_cnt_nxt = WAIT_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else if (wait_cnt == 4'd0) begin
          xfer_done = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt    = ACCESS;
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_en = xfer_done && s_apb_pwrite && !addr_err;
  assign tick  = ctrl_en && (presc_cnt == prescale);
  assign match = tick && (count == compare);

  // Bus writes take priority over the timer's own update in the same cycle;
  // a new match takes priority over a W1C of pending.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      ctrl_en   <= 1'b0;
      ctrl_ar   <= 1'b0;
      ctrl_ie   <= 1'b0;
      prescale  <= PRESCALE_RESET;
      presc_cnt <= '0;
      compare   <= 32'hFFFF_FFFF;
      count     <= '0;
      pending   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (!ctrl_en || tick) presc_cnt <= '0;
      else                  presc_cnt <= presc_cnt + 16'd1;

      if (wr_en && addr_idx == 3'd0) {ctrl_ie, ctrl_ar, ctrl_en} <= s_apb_pwdata[2:0];
      else if (match && !ctrl_ar)    ctrl_en <= 1'b0;

      if (wr_en && addr_idx == 3'd1) prescale <= s_apb_pwdata[15:0];
      if (wr_en && addr_idx == 3'd2) compare  <= s_apb_pwdata;

      if (wr_en && addr_idx == 3'd3) count <= s_apb_pwdata;
      else if (tick) begin
        if (!match)       count <= count + 32'd1;
        else if (ctrl_ar) count <= '0;
      end

      if (match)                                          pending <= 1'b1;
      else if (wr_en && addr_idx == 3'd4 && s_apb_pwdata[0]) pending <= 1'b0;

      irq <= pending && ctrl_ie;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr_idx)
      3'd0:    rdata = {29'd0, ctrl_ie, ctrl_ar, ctrl_en};
      3'd1:    rdata = {16'd0, prescale};
      3'd2:    rdata = compare;
      3'd3:    rdata = count;
      3'd4:    rdata = {31'd0, pending};
      default: rdata = '0;
    endcase
  end

  assign s_apb_pready    = xfer_done;
  assign s_apb_prdata    = (xfer_done && !s_apb_pwrite) ? rdata : 32'd0;
  assign s_apb_pslverror = xfer_done && addr_err;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Scoreboard bench for apb_timer_slave: driver pushes expected responses,
// a negedge monitor pops them on pready and checks irq against a timer model.
module tb_apb_timer_slave;

  localparam int          WS     = 2;
  localparam logic [15:0] PR_RST = 16'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        pready, pslverror, irq;
  logic [31:0] prdata;

  apb_timer_slave #(.ADDR_WIDTH(32), .WAIT_STATES(WS), .PRESCALE_RESET(PR_RST)) dut (
    .io_mainClk(clk), .io_asyncReset(rst),
    .s_apb_paddr(paddr), .s_apb_psel(psel), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
    .s_apb_pready(pready), .s_apb_prdata(prdata), .s_apb_pslverror(pslverror),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit          m_rst, m_en, m_ar, m_ie, m_pend, m_irq;
  logic [15:0] m_presc, m_pcnt;
  logic [31:0] m_cmp, m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0; m_irq = 0;
    m_presc = PR_RST; m_pcnt = 0; m_cmp = 32'hFFFF_FFFF; m_count = 0;
  endtask

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0: return {29'd0, m_ie, m_ar, m_en};
      1: return {16'd0, m_presc};
      2: return m_cmp;
      3: return m_count;
      4: return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge of the timer, written from the behavioural rules.
  task automatic model_edge(input bit wr, input int idx, input logic [31:0] d);
    bit tick, hit, n_en, n_pend;
    logic [31:0] n_count;
    if (m_rst) return;
    tick    = m_en && (m_pcnt == m_presc);
    hit     = tick && (m_count == m_cmp);
    n_en    = m_en;
    n_count = m_count;
    n_pend  = m_pend;
    if (tick) begin
      if (hit) begin
        if (m_ar) n_count = 0;
        else      n_en = 0;
      end else n_count = m_count + 1;
    end
    m_irq  = m_pend && m_ie;
    m_pcnt = (m_en && !tick) ? m_pcnt + 16'd1 : 16'd0;
    if (wr) begin
      case (idx)
        0: begin n_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
        1: m_presc = d[15:0];
        2: m_cmp = d;
        3: n_count = d;
        4: if (d[0]) n_pend = 0;
        default: ;
      endcase
    end
    if (hit) n_pend = 1;
    m_en = n_en; m_count = n_count; m_pend = n_pend;
  endtask

  task automatic cycle(input bit wr = 0, input int idx = 0, input logic [31:0] d = 0);
    @(posedge clk);
    model_edge(wr, idx, d);
    #1;
  endtask

  task automatic apb(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit use_exp = 0, input logic [31:0] exp_v = 0);
    int   idx;
    bit   err;
    exp_t e;
    idx = int'(a[4:2]);
    err = (idx > 4);
    paddr = a; pwrite = w; pwdata = d; psel = 1; penable = 0;
    cycle();
    penable = 1;
    repeat (WS) cycle();
    e.err   = err;
    e.rdata = (w || err) ? 32'd0 : (use_exp ? exp_v : model_read(idx));
    q.push_back(e);
    cycle(w && !err, idx, d);
    psel = 0; penable = 0; pwrite = 0;
    chk("pready_seen", 32'(q.size()), 32'd0);
  endtask

  task automatic rd_const(input logic [31:0] a, input logic [31:0] v);
    apb(0, a, 32'd0, 1, v);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pready) begin
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_pready: got 1 expected 0 at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("prdata", prdata, e.rdata);
        chk("pslverror", {31'd0, pslverror}, {31'd0, e.err});
      end
    end else begin
      chk("prdata_idle", prdata, 32'd0);
      chk("pslverror_idle", {31'd0, pslverror}, 32'd0);
    end
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
  end

  initial begin
    m_rst = 1;
    model_reset();
    cycle(); cycle();
    rst = 0; m_rst = 0;
    cycle();

    // prescaled auto-reload: pending on the 20th edge, irq one edge later
    apb(1, 32'h04, 32'd3);
    apb(1, 32'h08, 32'd4);
    apb(1, 32'h00, 32'h7);
    repeat (20) cycle();
    chk("irq_before_match", {31'd0, irq}, 32'd0);
    cycle();
    chk("irq_after_match", {31'd0, irq}, 32'd1);
    repeat (30) cycle();
    rd_const(32'h10, 32'd1);
    rd_const(32'h00, 32'd7);
    apb(0, 32'h0C, 0);

    // one-shot
    apb(1, 32'h00, 32'd0);
    apb(1, 32'h10, 32'd1);
    apb(1, 32'h0C, 32'd0);
    apb(1, 32'h04, 32'd0);
    apb(1, 32'h08, 32'd2);
    apb(1, 32'h00, 32'h5);
    repeat (10) cycle();
    rd_const(32'h00, 32'h4);
    rd_const(32'h0C, 32'd2);
    rd_const(32'h10, 32'd1);

    // reset in the middle of an access phase (irq is high here)
    paddr = 32'h08; pwrite = 1; pwdata = 32'h1234; psel = 1; penable = 0;
    cycle();
    penable = 1;
    cycle();
    rst = 1; m_rst = 1; model_reset();
    #1;
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverror", {31'd0, pslverror}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    psel = 0; penable = 0; pwrite = 0;
    cycle(); cycle();
    rst = 0; m_rst = 0;
    cycle();
    rd_const(32'h00, 32'd0);
    rd_const(32'h04, {16'd0, PR_RST});
    rd_const(32'h08, 32'hFFFF_FFFF);
    rd_const(32'h0C, 32'd0);
    rd_const(32'h10, 32'd0);

    // psel dropped during the access phase: no write
    paddr = 32'h08; pwrite = 1; pwdata = 32'h55; psel = 1; penable = 0;
    cycle();
    penable = 1;
    cycle();
    psel = 0; penable = 0; pwrite = 0;
    cycle(); cycle();
    rd_const(32'h08, 32'hFFFF_FFFF);

    // 32-bit wrap without match
    apb(1, 32'h04, 32'd0);
    apb(1, 32'h08, 32'h10);
    apb(1, 32'h0C, 32'hFFFF_FFFF);
    apb(1, 32'h00, 32'h1);
    apb(1, 32'h00, 32'h0);
    rd_const(32'h0C, 32'd3);
    rd_const(32'h10, 32'd0);

    // error offsets
    apb(0, 32'h14, 0);
    apb(1, 32'h18, 32'hFFFF_FFFF);
    apb(0, 32'h1C, 0);
    rd_const(32'h00, 32'd0);

    // W1C landing on every match phase
    apb(1, 32'h08, 32'd3);
    apb(1, 32'h0C, 32'd0);
    apb(1, 32'h00, 32'h7);
    for (int g = 0; g < 5; g++) begin
      apb(1, 32'h10, 32'd1);
      repeat (g) cycle();
    end
    apb(0, 32'h10, 0);
    apb(1, 32'h00, 32'h0);
    apb(1, 32'h10, 32'd1);

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      int          idx;
      logic [31:0] a, d;
      idx = int'($urandom_range(0, 7));
      a   = ($urandom() & ~32'h1C) | (32'(idx) << 2);
      case (idx)
        0: d = $urandom_range(0, 7);
        1: d = $urandom_range(0, 3);
        2: d = $urandom_range(0, 24);
        3: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 24);
        4: d = $urandom_range(0, 1);
        default: d = $urandom();
      endcase
      apb($urandom_range(0, 1) == 1, a, d);
      repeat ($urandom_range(0, 3)) cycle();
    end

    cycle(); cycle();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
